// File: rtl/denise_pkg.sv
// Shared Denise definitions: register word addresses, CLXCON field positions
// and the small match helpers used by the collision detector.
package denise_pkg;

    localparam logic [8:0] CLXCON = 9'h098;
    localparam logic [8:0] CLXDAT = 9'h00E;

    localparam int MVBP_LSB = 0;
    localparam int ENBP_LSB = 6;
    localparam int ENSP_LSB = 12;

    // A disabled plane always matches; an enabled one must equal its match value.
    function automatic logic [6:1] plane_match(input logic [6:1] bpl,
                                               input logic [6:1] enbp,
                                               input logic [6:1] mvbp);
        return ~enbp | ~(bpl ^ mvbp);
    endfunction

    // Group g is the even sprite 2g, plus the odd sprite 2g+1 when ENSP enables it.
    function automatic logic [3:0] sprite_groups(input logic [7:0] nsprite,
                                                 input logic [3:0] ensp);
        logic [3:0] grp;
        grp = 4'h0;
        for (int g = 0; g < 4; g++) begin
            grp[g] = nsprite[2*g] | (ensp[g] & nsprite[2*g+1]);
        end
        return grp;
    endfunction

endpackage

// File: rtl/denise_clxdet.sv
// Denise collision detector: CLXCON-programmed plane/sprite match with a
// read-to-clear CLXDAT accumulator driving the wired-OR register read bus.
module denise_clxdet
    import denise_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clk7_en,
    input  logic [8:1]  reg_address_in,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    input  logic        dblpf,
    input  logic [6:1]  bpldata,
    input  logic [7:0]  nsprite
);

    logic [15:0] clxcon_q, clxcon_d;
    logic [14:0] clxdat_q, clxdat_d;
    logic        con_sel_s, dat_sel_s;
    logic [6:1]  bm_s;
    logic        even_s, odd_s;
    logic [3:0]  grp_s;
    logic [14:0] cl_s;

    // Address decode and per-pixel collision vector.
    always_comb begin
        con_sel_s = (reg_address_in == CLXCON[8:1]);
        dat_sel_s = (reg_address_in == CLXDAT[8:1]);
        bm_s      = plane_match(bpldata, clxcon_q[ENBP_LSB +: 6], clxcon_q[MVBP_LSB +: 6]);
        even_s    = bm_s[2] & bm_s[4] & bm_s[6];
        // Outside dual-playfield the odd group only counts when the even planes match too.
        odd_s     = bm_s[1] & bm_s[3] & bm_s[5] & (dblpf | even_s);
        grp_s     = sprite_groups(nsprite, clxcon_q[ENSP_LSB +: 4]);
        cl_s      = 15'h0000;
        cl_s[0]   = even_s & odd_s;
        cl_s[4:1] = {4{odd_s}} & grp_s;
        cl_s[8:5] = {4{even_s}} & grp_s;
        cl_s[9]   = grp_s[0] & grp_s[1];
        cl_s[10]  = grp_s[0] & grp_s[2];
        cl_s[11]  = grp_s[0] & grp_s[3];
        cl_s[12]  = grp_s[1] & grp_s[2];
        cl_s[13]  = grp_s[1] & grp_s[3];
        cl_s[14]  = grp_s[2] & grp_s[3];
    end

    // Next-state: a CLXDAT read wins over any collision seen in the same slot.
    always_comb begin
        clxcon_d = clxcon_q;
        clxdat_d = clxdat_q;
        if (con_sel_s) begin
            clxcon_d = data_in;
        end else begin
            clxcon_d = clxcon_q;
        end
        if (dat_sel_s) begin
            clxdat_d = 15'h0000;
        end else begin
            clxdat_d = clxdat_q | cl_s;
        end
    end

    // State registers advance only on 7 MHz enable slots.
    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (reset) begin
                clxcon_q <= 16'h0000;
                clxdat_q <= 15'h0000;
            end else begin
                clxcon_q <= clxcon_d;
                clxdat_q <= clxdat_d;
            end
        end
    end

    // Read bus shows the pre-clear value with bit 15 always set.
    always_comb begin
        if (dat_sel_s) begin
            data_out = {1'b1, clxdat_q};
        end else begin
            data_out = 16'h0000;
        end
    end

endmodule

// File: tb/tb_denise_clxdet.sv
// Directed bench for denise_clxdet with a scoreboard of expected read values.
module tb_denise_clxdet;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk7_en;
    logic [8:1]  reg_address_in;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        dblpf;
    logic [6:1]  bpldata;
    logic [7:0]  nsprite;

    localparam logic [8:1] A_NONE    = 8'h00;
    localparam logic [8:1] A_CLXDAT  = 8'h07;
    localparam logic [8:1] A_CLXCON  = 8'h4C;
    localparam logic [8:1] A_CLXCON2 = 8'h87;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_v;

    denise_clxdet dut (
        .clk(clk), .reset(reset), .clk7_en(clk7_en),
        .reg_address_in(reg_address_in), .data_in(data_in), .data_out(data_out),
        .dblpf(dblpf), .bpldata(bpldata), .nsprite(nsprite)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick7();
        @(negedge clk);
        clk7_en = 1'b1;
        @(negedge clk);
        clk7_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic write_con(input logic [8:1] a, input logic [15:0] v);
        reg_address_in = a;
        data_in        = v;
        tick7();
        reg_address_in = A_NONE;
        data_in        = 16'h0000;
    endtask

    task automatic clear_dat();
        reg_address_in = A_CLXDAT;
        tick7();
        reg_address_in = A_NONE;
    endtask

    task automatic pixel(input logic dp, input logic [6:1] bpl, input logic [7:0] ns);
        dblpf          = dp;
        bpldata        = bpl;
        nsprite        = ns;
        reg_address_in = A_NONE;
        tick7();
    endtask

    // Compare data_out at address a against the oldest scoreboard entry.
    task automatic check_bus(input string tag, input logic [8:1] a);
        reg_address_in = a;
        #1;
        exp_v = exp_q.pop_front();
        total++;
        assert (data_out === exp_v) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, data_out, exp_v);
        end
    endtask

    // Read CLXDAT, then let the read clear it on the next enable slot.
    task automatic read_clr(input string tag);
        check_bus(tag, A_CLXDAT);
        tick7();
        reg_address_in = A_NONE;
    endtask

    initial begin
        reset = 1'b1; clk7_en = 1'b0; reg_address_in = A_NONE; data_in = 16'h0000;
        dblpf = 1'b0; bpldata = 6'b000000; nsprite = 8'h00;
        tick7();
        reset = 1'b0;

        exp_q.push_back(16'h0000); check_bus("reset_noaddr", A_NONE);
        exp_q.push_back(16'h8000); check_bus("reset_read", A_CLXDAT);
        reg_address_in = A_NONE;
        tick7();
        exp_q.push_back(16'h8001); check_bus("planes_always", A_CLXDAT);
        reg_address_in = A_NONE;
        exp_q.push_back(16'h0000); check_bus("con_not_readable", A_CLXCON);
        reg_address_in = A_NONE;

        // Reset and a held CLXDAT address do nothing without clk7_en.
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        reg_address_in = A_CLXDAT;
        repeat (3) @(negedge clk);
        exp_q.push_back(16'h8001); check_bus("hold_no_en", A_CLXDAT);
        tick7();
        exp_q.push_back(16'h8000); check_bus("clear_priority", A_CLXDAT);
        reg_address_in = A_NONE;

        write_con(A_CLXCON, 16'h0FFF);
        clear_dat();
        pixel(1'b1, 6'b111111, 8'h00);
        exp_q.push_back(16'h8001); read_clr("evenodd_hit");
        exp_q.push_back(16'h8000); check_bus("evenodd_cleared", A_CLXDAT);
        tick7();
        pixel(1'b1, 6'b010101, 8'h00);
        exp_q.push_back(16'h8000); read_clr("evenodd_miss");

        write_con(A_CLXCON, 16'h0FC0);
        clear_dat();
        pixel(1'b1, 6'b000000, 8'h04);
        exp_q.push_back(16'h8045); read_clr("sprite_plane_g1");

        write_con(A_CLXCON, 16'h0000);
        clear_dat();
        pixel(1'b1, 6'b000000, 8'h03);
        exp_q.push_back(16'h8023); read_clr("spr0_spr1");
        clear_dat();
        pixel(1'b1, 6'b000000, 8'h0A);
        exp_q.push_back(16'h8001); read_clr("odd_spr_disabled");
        clear_dat();
        pixel(1'b1, 6'b000000, 8'h41);
        exp_q.push_back(16'h8933); read_clr("g0_g3");

        write_con(A_CLXCON, 16'h3000);
        clear_dat();
        pixel(1'b1, 6'b000000, 8'h0A);
        exp_q.push_back(16'h8267); read_clr("ensp1_ensp3");

        write_con(A_CLXCON, 16'hC000);
        clear_dat();
        pixel(1'b1, 6'b000000, 8'hA0);
        exp_q.push_back(16'hC199); read_clr("ensp5_ensp7");

        write_con(A_CLXCON, 16'h0FFF);
        clear_dat();
        pixel(1'b0, 6'b010101, 8'h01);
        exp_q.push_back(16'h8000); read_clr("single_pf_odd");
        clear_dat();
        pixel(1'b1, 6'b010101, 8'h01);
        exp_q.push_back(16'h8002); read_clr("dual_pf_odd");

        // CLXCON2 writes must leave CLXCON alone.
        write_con(A_CLXCON, 16'h0000);
        write_con(A_CLXCON2, 16'h0FFF);
        clear_dat();
        pixel(1'b1, 6'b000000, 8'h00);
        exp_q.push_back(16'h8001); read_clr("clxcon2_ignored");

        // Reset clears CLXCON and beats a simultaneous collision.
        write_con(A_CLXCON, 16'h0FFF);
        clear_dat();
        dblpf = 1'b1; bpldata = 6'b111111; nsprite = 8'h00;
        tick7();
        exp_q.push_back(16'h0000); check_bus("noaddr_with_data", A_NONE);
        reset = 1'b1;
        tick7();
        reset = 1'b0;
        exp_q.push_back(16'h8000); check_bus("reset_clears_dat", A_CLXDAT);
        reg_address_in = A_NONE;
        pixel(1'b0, 6'b000000, 8'h00);
        exp_q.push_back(16'h8001); read_clr("reset_clears_con");

        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_empty: got %0d expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
